// File: rtl/led_pkg.sv
// Shared definitions for the LED panel pipeline.
// Holds the panel geometry, the frame-buffer write-state encoding and the
// RGB pixel type. Modules that need these import led_pkg::*.
package led_pkg;
  localparam int H_LEN   = 64;   // pixels per row
  localparam int V_HALF  = 32;   // rows per half panel
  localparam int COLOR_W = 8;    // bits per colour channel
  localparam int ADDR_W  = 11;   // log2(H_LEN*V_HALF)

  typedef enum logic [1:0] {
    IDLE = 2'd0,   // waiting for start of frame
    FILL = 2'd1,   // writing pixels into the back bank
    FULL = 2'd2    // back bank complete, waiting to swap
  } fb_wr_state_t;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;
endpackage

// File: rtl/frame_buffer_if.sv
// Pixel stream into the frame buffer (valid/ready with start-of-frame).
//   i_valid  pixel valid          (master -> slave)
//   i_sof    first pixel of frame (master -> slave, qualified by i_valid)
//   i_data   pixel {R,G,B}        (master -> slave)
//   o_ready  slave can accept     (slave -> master)
interface frame_buffer_if #(parameter int DATA_W = 24);
  logic              i_valid;
  logic              o_ready;
  logic              i_sof;
  logic [DATA_W-1:0] i_data;

  modport master (output i_valid, i_sof, i_data, input  o_ready);
  modport slave  (input  i_valid, i_sof, i_data, output o_ready);
endinterface

// File: rtl/fb_bank_ram.sv
// One frame-buffer bank: simple dual-port RAM.
// Each word holds the top-half pixel and the bottom-half pixel that share a
// scanner address; each half has its own write enable.
//   i_clk, i_reset_n       clock, synchronous active-low reset (read reg only)
//   i_we_top, i_we_bot     half-word write enables
//   i_wr_addr, i_wr_data   write port
//   i_rd_addr              read address, sampled every edge
//   o_rd_data              registered {top, bottom}
module fb_bank_ram #(
  parameter int AW = 11,
  parameter int DW = 24
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_we_top,
  input  logic            i_we_bot,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [DW-1:0]   i_wr_data,
  input  logic [AW-1:0]   i_rd_addr,
  output logic [2*DW-1:0] o_rd_data
);
  logic [DW-1:0]   r_mem_top [2**AW];
  logic [DW-1:0]   r_mem_bot [2**AW];
  logic [2*DW-1:0] r_rd_data;

  // Storage is never reset; only the read register is.
  always_ff @(posedge i_clk) begin
    if (i_we_top) r_mem_top[i_wr_addr] <= i_wr_data;
    if (i_we_bot) r_mem_bot[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_rd_data <= '0;
    else            r_rd_data <= {r_mem_top[i_rd_addr], r_mem_bot[i_rd_addr]};
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/frame_buffer.sv
// Double-buffered pixel store feeding the HUB75 scanner.
// A raster-order pixel stream fills the back bank; the scanner reads the
// front bank (top and bottom halves in parallel, 1-cycle latency). Banks
// swap only when the scanner wraps from the last row back to row 0.
//   i_clk, i_reset_n     clock, synchronous active-low reset
//   i_pix                pixel stream (slave side)
//   i_rd_address         scanner address = row*H_LEN + x
//   o_R0/o_G0/o_B0       top-half pixel
//   o_R1/o_G1/o_B1       bottom-half pixel (row + V_HALF)
//   o_front_bank         bank currently displayed
//   o_frame_drop         one-cycle pulse when a partial frame is restarted
module frame_buffer #(
  parameter int H_LEN   = led_pkg::H_LEN,
  parameter int V_HALF  = led_pkg::V_HALF,
  parameter int COLOR_W = led_pkg::COLOR_W,
  parameter int ADDR_W  = led_pkg::ADDR_W
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  frame_buffer_if.slave      i_pix,
  input  logic [ADDR_W-1:0]  i_rd_address,
  output logic [COLOR_W-1:0] o_R0,
  output logic [COLOR_W-1:0] o_G0,
  output logic [COLOR_W-1:0] o_B0,
  output logic [COLOR_W-1:0] o_R1,
  output logic [COLOR_W-1:0] o_G1,
  output logic [COLOR_W-1:0] o_B1,
  output logic               o_front_bank,
  output logic               o_frame_drop
);
  import led_pkg::*;

  localparam int X_W = $clog2(H_LEN);
  localparam int Y_W = $clog2(2*V_HALF);
  localparam int P_W = X_W + Y_W;
  localparam int D_W = 3*COLOR_W;
  localparam int R_W = ADDR_W - X_W;
  localparam logic [P_W-1:0] LAST_PIX = P_W'(2*V_HALF*H_LEN - 1);
  localparam logic [R_W-1:0] LAST_ROW = R_W'(V_HALF - 1);

  fb_wr_state_t      r_state;
  logic [P_W-1:0]    r_pix_cnt;
  logic              r_swap_pending;
  logic              r_front_bank;
  logic              r_frame_drop;
  logic [ADDR_W-1:0] r_prev_addr;

  logic              w_xfer;
  logic              w_wr_en;
  logic              w_boundary;
  logic [P_W-1:0]    w_pix;
  logic              w_half;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [2*D_W-1:0]  w_rd [2];

  assign i_pix.o_ready = (r_state != FULL);
  assign w_xfer        = i_pix.i_valid && i_pix.o_ready;
  // In IDLE only a start-of-frame pixel is stored; FULL never transfers.
  assign w_wr_en       = i_reset_n && w_xfer && (i_pix.i_sof || r_state == FILL);

  // A start-of-frame pixel is always pixel 0, even as a restart in FILL.
  assign w_pix     = i_pix.i_sof ? '0 : r_pix_cnt;
  assign w_half    = w_pix[P_W-1];
  assign w_wr_addr = w_pix[P_W-2:0];

  assign w_boundary = (r_prev_addr[ADDR_W-1:X_W] == LAST_ROW) &&
                      (i_rd_address[ADDR_W-1:X_W] == '0);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state        <= IDLE;
      r_pix_cnt      <= '0;
      r_swap_pending <= 1'b0;
      r_front_bank   <= 1'b0;
      r_frame_drop   <= 1'b0;
      r_prev_addr    <= '0;
    end else begin
      r_prev_addr  <= i_rd_address;
      r_frame_drop <= 1'b0;
      case (r_state)
        IDLE: if (w_xfer && i_pix.i_sof) begin
          r_pix_cnt <= P_W'(1);
          r_state   <= FILL;
        end
        FILL: if (w_xfer) begin
          if (i_pix.i_sof) begin
            r_frame_drop <= 1'b1;
            r_pix_cnt    <= P_W'(1);
          end else if (r_pix_cnt == LAST_PIX) begin
            r_pix_cnt      <= '0;
            r_swap_pending <= 1'b1;
            r_state        <= FULL;
          end else begin
            r_pix_cnt <= r_pix_cnt + 1'b1;
          end
        end
        FULL: if (r_swap_pending && w_boundary) begin
          r_front_bank   <= ~r_front_bank;
          r_swap_pending <= 1'b0;
          r_state        <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Both banks read every cycle; the front-bank register picks the output,
  // so data from a newly swapped-in bank appears right after the swap edge.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic w_we;
    assign w_we = w_wr_en && (r_front_bank != (b == 1));
    fb_bank_ram #(.AW(ADDR_W), .DW(D_W)) u_ram (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_we_top  (w_we && !w_half),
      .i_we_bot  (w_we &&  w_half),
      .i_wr_addr (w_wr_addr),
      .i_wr_data (i_pix.i_data),
      .i_rd_addr (i_rd_address),
      .o_rd_data (w_rd[b])
    );
  end

  assign {o_R0, o_G0, o_B0, o_R1, o_G1, o_B1} = w_rd[r_front_bank];
  assign o_front_bank = r_front_bank;
  assign o_frame_drop = r_frame_drop;
endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer: reset, discard in IDLE, full frame and
// swap, restart, backpressure in FULL, boundary coinciding with the last
// pixel, and reset mid-frame.
`timescale 1ns/1ps
module tb_frame_buffer;
  import led_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [COLOR_W-1:0] r0, g0, b0, r1, g1, b1;
  logic              front, drop;
  logic [23:0]       top, bot;
  int                total = 0, bad = 0, drops = 0;

  frame_buffer_if #(.DATA_W(24)) pix_if();

  frame_buffer dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_pix        (pix_if),
    .i_rd_address (rd_addr),
    .o_R0 (r0), .o_G0 (g0), .o_B0 (b0),
    .o_R1 (r1), .o_G1 (g1), .o_B1 (b1),
    .o_front_bank (front),
    .o_frame_drop (drop)
  );

  always #5 clk = ~clk;
  assign top = {r0, g0, b0};
  assign bot = {r1, g1, b1};

  always @(negedge clk) if (drop) drops++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] px(input int y, input int x, input logic [7:0] b);
    rgb_t p;
    p.r = 8'(y);
    p.g = 8'(x);
    p.b = b;
    return p;
  endfunction

  task automatic push(input logic sof, input int n, input logic [7:0] b);
    pix_if.i_valid = 1'b1;
    pix_if.i_sof   = sof;
    pix_if.i_data  = px(n / 64, n % 64, b);
    tick();
  endtask

  initial begin
    pix_if.i_valid = 1'b0;
    pix_if.i_sof   = 1'b0;
    pix_if.i_data  = '0;

    // reset
    rst_n = 1'b0; tick(); tick();
    chk("rst_top", top, 0);
    chk("rst_bot", bot, 0);
    chk("rst_front", front, 0);
    chk("rst_drop", drop, 0);
    rst_n = 1'b1; tick();
    chk("idle_ready", pix_if.o_ready, 1);

    // pixel without sof in IDLE is dropped
    pix_if.i_valid = 1'b1; pix_if.i_sof = 1'b0; pix_if.i_data = 24'h123456;
    tick();
    pix_if.i_valid = 1'b0;
    chk("discard_cnt", dut.r_pix_cnt, 0);
    chk("discard_state", dut.r_state, IDLE);

    // frame A into bank 1
    for (int n = 0; n < 4096; n++) push(n == 0, n, 8'hA5);
    pix_if.i_valid = 1'b0;
    chk("fullA_ready", pix_if.o_ready, 0);
    chk("fullA_front", front, 0);
    tick();
    chk("fullA_wait", pix_if.o_ready, 0);
    rd_addr = 11'(31*64+63); tick();
    chk("preA_ready", pix_if.o_ready, 0);
    chk("preA_front", front, 0);
    rd_addr = '0; tick();
    chk("swapA_front", front, 1);
    chk("swapA_ready", pix_if.o_ready, 1);
    chk("swapA_top0", top, px(0, 0, 8'hA5));
    chk("swapA_bot0", bot, px(32, 0, 8'hA5));
    rd_addr = 11'(5*64+7); tick();
    chk("A_top", top, px(5, 7, 8'hA5));
    chk("A_bot", bot, px(37, 7, 8'hA5));

    // frame B restarted at pixel 100
    rd_addr = '0;
    for (int n = 0; n < 100; n++) push(n == 0, n, 8'h3C);
    push(1'b1, 0, 8'h3C);
    chk("restart_drop", drop, 1);
    chk("restart_cnt", dut.r_pix_cnt, 1);
    pix_if.i_valid = 1'b0; tick();
    chk("drop_1cyc", drop, 0);
    for (int n = 1; n < 4096; n++) push(1'b0, n, 8'h3C);

    // backpressure in FULL: valid held, nothing accepted
    pix_if.i_valid = 1'b1; pix_if.i_sof = 1'b1; pix_if.i_data = px(0, 0, 8'hC3);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_ready", pix_if.o_ready, 0);
      chk("bp_top0", top, px(0, 0, 8'hA5));
    end
    rd_addr = 11'(31*64+63); tick();
    chk("preB_ready", pix_if.o_ready, 0);
    rd_addr = '0; tick();
    chk("swapB_front", front, 0);
    chk("swapB_top0", top, px(0, 0, 8'h3C));
    chk("swapB_bot0", bot, px(32, 0, 8'h3C));
    tick();  // held sof pixel now accepted in IDLE
    chk("resume_cnt", dut.r_pix_cnt, 1);
    chk("resume_state", dut.r_state, FILL);
    pix_if.i_sof = 1'b0;

    // frame C: boundary lands on the last pixel edge
    for (int n = 1; n < 4096; n++) begin
      if (n == 4094) rd_addr = 11'(31*64+63);
      else if (n == 4095) rd_addr = '0;
      push(1'b0, n, 8'hC3);
    end
    pix_if.i_valid = 1'b0;
    chk("coinc_front", front, 0);
    chk("coinc_ready", pix_if.o_ready, 0);
    rd_addr = 11'(5*64+7); tick();
    chk("coinc_hold", front, 0);
    chk("B_top", top, px(5, 7, 8'h3C));
    chk("B_bot", bot, px(37, 7, 8'h3C));
    rd_addr = 11'(31*64+63); tick();
    rd_addr = '0; tick();
    chk("swapC_front", front, 1);
    rd_addr = 11'(5*64+7); tick();
    chk("C_top", top, px(5, 7, 8'hC3));
    chk("C_bot", bot, px(37, 7, 8'hC3));

    // reset in the middle of a frame
    rd_addr = '0;
    for (int n = 0; n < 2000; n++) push(n == 0, n, 8'h5A);
    pix_if.i_valid = 1'b0;
    chk("pre_rst_cnt", dut.r_pix_cnt, 2000);
    rst_n = 1'b0; tick();
    chk("mrst_state", dut.r_state, IDLE);
    chk("mrst_cnt", dut.r_pix_cnt, 0);
    chk("mrst_front", front, 0);
    chk("mrst_drop", drop, 0);
    chk("mrst_top", top, 0);
    rst_n = 1'b1; tick();
    chk("mrst_ready", pix_if.o_ready, 1);
    chk("drop_count", drops, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
